// File: rtl/dma_reg_file.sv
// Multi-channel DMA register file: byte-serial CPU access to address/count registers,
// plus transfer-step bookkeeping with terminal-count, autoinit reload and masking.
module dma_reg_file #(
    parameter int NUM_CH = 4,
    parameter int AW     = 16,
    parameter int WW     = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                cpu_wr,
    input  logic                cpu_rd,
    input  logic [3:0]          cpu_fn,
    input  logic [2:0]          cpu_ch,
    input  logic [7:0]          cpu_din,
    output logic [7:0]          cpu_dout,
    input  logic [2:0]          xfer_ch,
    input  logic                xfer_step,
    input  logic                temp_we,
    input  logic [7:0]          temp_din,
    output logic [AW-1:0]       cur_addr,
    output logic [7:0]          command,
    output logic [6*NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0]   mask,
    output logic [NUM_CH-1:0]   request,
    output logic                tc
);
    localparam int AB = AW / 8;
    localparam int WB = WW / 8;

    localparam logic [3:0] FN_ADDR   = 4'd0;
    localparam logic [3:0] FN_CNT    = 4'd1;
    localparam logic [3:0] FN_CMD    = 4'd2;
    localparam logic [3:0] FN_REQ    = 4'd3;
    localparam logic [3:0] FN_MASK   = 4'd4;
    localparam logic [3:0] FN_MODE   = 4'd5;
    localparam logic [3:0] FN_CLRBP  = 4'd6;
    localparam logic [3:0] FN_MCLR   = 4'd7;
    localparam logic [3:0] FN_CLRMSK = 4'd8;
    localparam logic [3:0] FN_WRMSK  = 4'd9;
    localparam logic [3:0] FN_TEMP   = 4'd10;

    logic [AW-1:0]     base_addr_q [NUM_CH];
    logic [AW-1:0]     base_addr_d [NUM_CH];
    logic [AW-1:0]     cur_addr_q  [NUM_CH];
    logic [AW-1:0]     cur_addr_d  [NUM_CH];
    logic [WW-1:0]     base_cnt_q  [NUM_CH];
    logic [WW-1:0]     base_cnt_d  [NUM_CH];
    logic [WW-1:0]     cur_cnt_q   [NUM_CH];
    logic [WW-1:0]     cur_cnt_d   [NUM_CH];
    logic [5:0]        mode_q      [NUM_CH];
    logic [5:0]        mode_d      [NUM_CH];
    logic [7:0]        command_q, command_d;
    logic [7:0]        temp_q, temp_d;
    logic [7:0]        dout_q, dout_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] request_q, request_d;
    logic [NUM_CH-1:0] tcf_q, tcf_d;
    logic [NUM_CH-1:0] tc_set;
    logic [1:0]        bp_q, bp_d;
    logic              tc_q, tc_d;
    logic              mclr;

    function automatic logic [31:0] put_byte(input logic [31:0] v, input logic [1:0] idx,
                                             input int nbytes, input logic [7:0] b);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (i < nbytes && idx == 2'(i)) r[i*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] v, input logic [1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++)
            if (idx == 2'(i)) r = v[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [1:0] next_bp(input logic [1:0] bp, input int nbytes);
        return (int'(bp) >= nbytes - 1) ? 2'd0 : bp + 2'd1;
    endfunction

    assign mclr = cpu_wr && (cpu_fn == FN_MCLR);

    always_comb begin
        base_addr_d = base_addr_q;
        cur_addr_d  = cur_addr_q;
        base_cnt_d  = base_cnt_q;
        cur_cnt_d   = cur_cnt_q;
        mode_d      = mode_q;
        command_d   = command_q;
        temp_d      = temp_q;
        dout_d      = dout_q;
        mask_d      = mask_q;
        request_d   = request_q;
        tcf_d       = tcf_q;
        bp_d        = bp_q;
        tc_d        = 1'b0;
        tc_set      = '0;

        // Transfer step first so that a same-cycle CPU write to the register overrides it.
        if (xfer_step && !command_q[2]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (xfer_ch == 3'(c)) begin
                    cur_addr_d[c] = mode_q[c][3] ? cur_addr_q[c] - AW'(1) : cur_addr_q[c] + AW'(1);
                    cur_cnt_d[c]  = cur_cnt_q[c] - WW'(1);
                    if (cur_cnt_q[c] == '0) begin
                        tc_d         = 1'b1;
                        tc_set[c]    = 1'b1;
                        request_d[c] = 1'b0;
                        if (mode_q[c][2]) begin
                            cur_addr_d[c] = base_addr_q[c];
                            cur_cnt_d[c]  = base_cnt_q[c];
                        end else begin
                            mask_d[c] = 1'b1;
                        end
                    end
                end
            end
        end

        if (cpu_wr) begin
            case (cpu_fn)
                FN_ADDR, FN_CNT, FN_REQ, FN_MASK, FN_MODE: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cpu_ch == 3'(c)) begin
                            case (cpu_fn)
                                FN_ADDR: begin
                                    base_addr_d[c] = AW'(put_byte(32'(base_addr_q[c]), bp_q, AB, cpu_din));
                                    cur_addr_d[c]  = AW'(put_byte(32'(cur_addr_q[c]), bp_q, AB, cpu_din));
                                    bp_d           = next_bp(bp_q, AB);
                                end
                                FN_CNT: begin
                                    base_cnt_d[c] = WW'(put_byte(32'(base_cnt_q[c]), bp_q, WB, cpu_din));
                                    cur_cnt_d[c]  = WW'(put_byte(32'(cur_cnt_q[c]), bp_q, WB, cpu_din));
                                    bp_d          = next_bp(bp_q, WB);
                                end
                                FN_REQ:  request_d[c] = cpu_din[0];
                                FN_MASK: mask_d[c]    = cpu_din[0];
                                default: mode_d[c]    = cpu_din[7:2];
                            endcase
                        end
                    end
                end
                FN_CMD:    command_d = cpu_din;
                FN_CLRBP:  bp_d      = 2'd0;
                FN_CLRMSK: mask_d    = '0;
                FN_WRMSK:  mask_d    = cpu_din[NUM_CH-1:0];
                default: ;
            endcase
        end

        if (cpu_rd) begin
            dout_d = 8'h00;
            case (cpu_fn)
                FN_ADDR: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cpu_ch == 3'(c)) begin
                            dout_d = get_byte(32'(cur_addr_q[c]), bp_q);
                            bp_d   = next_bp(bp_q, AB);
                        end
                    end
                end
                FN_CNT: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cpu_ch == 3'(c)) begin
                            dout_d = get_byte(32'(cur_cnt_q[c]), bp_q);
                            bp_d   = next_bp(bp_q, WB);
                        end
                    end
                end
                FN_CMD: begin
                    if (bp_q == 2'd0) begin
                        dout_d = 8'(tcf_q);
                        tcf_d  = '0;
                        bp_d   = 2'd1;
                    end else begin
                        dout_d = 8'(request_q);
                        bp_d   = 2'd0;
                    end
                end
                FN_TEMP: dout_d = temp_q;
                default: ;
            endcase
        end

        tcf_d = tcf_d | tc_set;
        if (temp_we) temp_d = temp_din;
    end

    always_ff @(posedge CLK) begin
        if (RESET || mclr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_addr_q[c] <= '0;
                cur_addr_q[c]  <= '0;
                base_cnt_q[c]  <= '0;
                cur_cnt_q[c]   <= '0;
                mode_q[c]      <= '0;
            end
            command_q <= '0;
            temp_q    <= '0;
            dout_q    <= '0;
            mask_q    <= '1;
            request_q <= '0;
            tcf_q     <= '0;
            bp_q      <= '0;
            tc_q      <= 1'b0;
        end else begin
            base_addr_q <= base_addr_d;
            cur_addr_q  <= cur_addr_d;
            base_cnt_q  <= base_cnt_d;
            cur_cnt_q   <= cur_cnt_d;
            mode_q      <= mode_d;
            command_q   <= command_d;
            temp_q      <= temp_d;
            dout_q      <= dout_d;
            mask_q      <= mask_d;
            request_q   <= request_d;
            tcf_q       <= tcf_d;
            bp_q        <= bp_d;
            tc_q        <= tc_d;
        end
    end

    always_comb begin
        cur_addr = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (xfer_ch == 3'(c)) cur_addr = cur_addr_q[c];
    end

    always_comb begin
        mode = '0;
        for (int c = 0; c < NUM_CH; c++) mode[c*6 +: 6] = mode_q[c];
    end

    assign cpu_dout = dout_q;
    assign command  = command_q;
    assign mask     = mask_q;
    assign request  = request_q;
    assign tc       = tc_q;
endmodule
